// File: rtl/mux2x1_pkg.sv
// Shared types and constants for the mux2x1 stimulus sequencer and its checker.
package mux2x1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mux_seq_state_t;

  localparam int MUX_NVEC  = 8;
  localparam int MUX_IDX_W = 3;

  // Golden 2:1 mux response for a vector index (sel = idx[2], in1 = idx[1], in2 = idx[0]).
  function automatic logic mux_expected(input logic [MUX_IDX_W-1:0] idx);
    return idx[2] ? idx[0] : idx[1];
  endfunction

endpackage

// File: rtl/mux2x1_chk.sv
// Mismatch counter for the mux2x1 sequencer: compares the returned mux output
// against the expected value on each sample strobe.
// Compiled only when MUX2X1_SEQ_CHECK_EN is defined; without it the checker
// does not exist in the build at all.
`ifdef MUX2X1_SEQ_CHECK_EN
module mux2x1_chk
  import mux2x1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_exp,
  input  logic       i_saida,
  input  logic       i_sample,
  input  logic       i_clear,
  output logic [3:0] o_err_cnt,
  output logic       o_err
);

  localparam logic [3:0] ERR_MAX = 4'(MUX_NVEC);

  logic [3:0] r_err_cnt;
  logic       r_err;
  logic       w_mismatch;

  assign w_mismatch = i_sample && (i_saida != i_exp);

  // Count mismatches (saturating at one per vector) and keep a sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_err_cnt <= 4'd0;
      r_err     <= 1'b0;
    end else if (w_mismatch) begin
      if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 4'd1;
      r_err <= 1'b1;
    end
  end

  assign o_err_cnt = r_err_cnt;
  assign o_err     = r_err;

endmodule
`endif

// File: rtl/mux2x1_seq.sv
// Synthesizable stimulus sequencer for the mux2x1 block: on start it walks
// (sel,in1,in2) through all 8 combinations, each held DWELL cycles, then
// pulses done for one cycle.
// Optional self-check enabled by defining MUX2X1_SEQ_CHECK_EN.
module mux2x1_seq
  import mux2x1_pkg::*;
#(
  parameter int DWELL = 10,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 saida_in,
  output logic                 in1,
  output logic                 in2,
  output logic                 sel,
  output logic [MUX_IDX_W-1:0] vec_idx,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           err_cnt,
  output logic                 err
);

  localparam logic [CNT_W-1:0]     DW_LAST  = CNT_W'(DWELL - 1);
  localparam logic [MUX_IDX_W-1:0] VEC_LAST = MUX_IDX_W'(MUX_NVEC - 1);

  mux_seq_state_t        r_state;
  mux_seq_state_t        w_next;
  logic [MUX_IDX_W-1:0]  r_vec;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_last_dwell;
  logic                  w_last_vec;
  logic                  w_start;
  logic                  w_busy;
  logic                  w_done;

  assign w_last_dwell = (r_cnt == DW_LAST);
  assign w_last_vec   = (r_vec == VEC_LAST);
  assign w_start      = (r_state == IDLE) && start;

  // State register; reset returns to IDLE on any edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: start only honoured in IDLE, DONE lasts a single cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last_dwell && w_last_vec) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      RUN:     w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  // Vector index and dwell counter; both parked at 0 outside RUN so the mux
  // inputs are driven low while idle.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_vec <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      if (w_last_dwell) begin
        r_cnt <= '0;
        r_vec <= w_last_vec ? '0 : r_vec + MUX_IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_vec <= '0;
      r_cnt <= '0;
    end
  end

  // The mux stimulus comes straight off the vector register bits.
  assign sel     = r_vec[2];
  assign in1     = r_vec[1];
  assign in2     = r_vec[0];
  assign vec_idx = r_vec;
  assign busy    = w_busy;
  assign done    = w_done;

`ifdef MUX2X1_SEQ_CHECK_EN
  logic w_sample;
  logic w_exp;

  // Sample in the last dwell cycle of each vector, giving the mux the full
  // dwell to settle.
  assign w_sample = (r_state == RUN) && w_last_dwell;
  assign w_exp    = mux_expected(r_vec);

  mux2x1_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_exp     (w_exp),
    .i_saida   (saida_in),
    .i_sample  (w_sample),
    .i_clear   (w_start),
    .o_err_cnt (err_cnt),
    .o_err     (err)
  );
`else
  logic w_unused_saida;

  assign w_unused_saida = saida_in;
  assign err_cnt        = 4'd0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mux2x1_seq.sv
// Bench for mux2x1_seq: instance 0 with DWELL=2, instance 1 with DWELL=1.
// The expected waveform is derived from cycles elapsed since start and a
// table of the 8 vectors; expected error counts come from the fault mode.
module tb_mux2x1_seq;

`ifdef MUX2X1_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // (in1,in2,sel) for vectors 0..7 in the order they must appear.
  localparam logic [2:0] SEQ [8] = '{3'b000, 3'b010, 3'b100, 3'b110,
                                     3'b001, 3'b011, 3'b101, 3'b111};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start   [2];
  logic       saida   [2];
  logic       in1     [2];
  logic       in2     [2];
  logic       sel     [2];
  logic [2:0] vec_idx [2];
  logic       busy    [2];
  logic       done    [2];
  logic [3:0] err_cnt [2];
  logic       err     [2];
  int         mode    [2];
  logic [7:0] fmask   [2];
  int         last_err[2];
  int         checks = 0;
  int         errors = 0;

  mux2x1_seq #(.DWELL(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .saida_in(saida[0]),
    .in1(in1[0]), .in2(in2[0]), .sel(sel[0]), .vec_idx(vec_idx[0]),
    .busy(busy[0]), .done(done[0]), .err_cnt(err_cnt[0]), .err(err[0])
  );

  mux2x1_seq #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .saida_in(saida[1]),
    .in1(in1[1]), .in2(in2[1]), .sel(sel[1]), .vec_idx(vec_idx[1]),
    .busy(busy[1]), .done(done[1]), .err_cnt(err_cnt[1]), .err(err[1])
  );

  // Device under test seen by the sequencer: a 2:1 mux, optionally faulty.
  // mode 0 good, 1 inverted, 2 stuck at 0, 3 inverted on vectors set in mask.
  function automatic logic mux_drv(input int m, input logic [7:0] msk,
                                   input logic a, input logic b, input logic s,
                                   input logic [2:0] v);
    logic good;
    good = s ? b : a;
    case (m)
      1:       return ~good;
      2:       return 1'b0;
      3:       return good ^ msk[v];
      default: return good;
    endcase
  endfunction

  assign saida[0] = mux_drv(mode[0], fmask[0], in1[0], in2[0], sel[0], vec_idx[0]);
  assign saida[1] = mux_drv(mode[1], fmask[1], in1[1], in2[1], sel[1], vec_idx[1]);

  // Whether the checker should flag vector v under fault mode m.
  function automatic int mism(input int m, input logic [7:0] msk, input int v);
    logic [2:0] t;
    logic good;
    t    = SEQ[v];
    good = t[0] ? t[1] : t[2];
    if (!CHK_EN) return 0;
    case (m)
      1:       return 1;
      2:       return good ? 1 : 0;
      3:       return msk[v] ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output of instance k against the expected vector/flags.
  task automatic chk_all(input int k, input string ph, input int v, input bit e_busy,
                         input bit e_done, input int e_err);
    logic [2:0] t;
    t = SEQ[v];
    chk($sformatf("%s.u%0d.vec_idx", ph, k), int'(vec_idx[k]), v);
    chk($sformatf("%s.u%0d.in1", ph, k), int'(in1[k]), int'(t[2]));
    chk($sformatf("%s.u%0d.in2", ph, k), int'(in2[k]), int'(t[1]));
    chk($sformatf("%s.u%0d.sel", ph, k), int'(sel[k]), int'(t[0]));
    chk($sformatf("%s.u%0d.busy", ph, k), int'(busy[k]), int'(e_busy));
    chk($sformatf("%s.u%0d.done", ph, k), int'(done[k]), int'(e_done));
    chk($sformatf("%s.u%0d.err_cnt", ph, k), int'(err_cnt[k]), e_err);
    chk($sformatf("%s.u%0d.err", ph, k), int'(err[k]), (e_err != 0) ? 1 : 0);
  endtask

  // One full sequence on instance k with dwell d; optionally re-pulse start
  // during RUN at cycle offset restart_at (must be ignored).
  task automatic run_seq(input int k, input int d, input int m, input logic [7:0] msk,
                         input int restart_at, input string ph);
    int run_err;
    mode[k]  = m;
    fmask[k] = msk;
    chk_all(k, {ph, ".idle"}, 0, 1'b0, 1'b0, last_err[k]);
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    run_err  = 0;
    for (int t = 0; t < 8 * d; t++) begin
      if (t > 0 && (t % d) == 0) run_err += mism(m, msk, t / d - 1);
      chk_all(k, $sformatf("%s.t%0d", ph, t), t / d, 1'b1, 1'b0, run_err);
      start[k] = (t == restart_at);
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
    run_err += mism(m, msk, 7);
    chk_all(k, {ph, ".done"}, 0, 1'b0, 1'b1, run_err);
    @(posedge clk); #1;
    chk_all(k, {ph, ".after"}, 0, 1'b0, 1'b0, run_err);
    last_err[k] = run_err;
  endtask

  initial begin
    rst_n    = 1'b0;
    start[0] = 1'b1;
    start[1] = 1'b1;
    mode[0]  = 0;
    mode[1]  = 0;
    fmask[0] = 8'h00;
    fmask[1] = 8'h00;
    last_err[0] = 0;
    last_err[1] = 0;

    // Reset held with start asserted: nothing may leave IDLE.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_all(0, $sformatf("rst%0d", c), 0, 1'b0, 1'b0, 0);
      chk_all(1, $sformatf("rst%0d", c), 0, 1'b0, 1'b0, 0);
    end
    start[0] = 1'b0;
    start[1] = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;

    // Directed sequences on DWELL=2.
    run_seq(0, 2, 0, 8'h00, -1, "good");
    run_seq(0, 2, 1, 8'h00, -1, "inv");
    run_seq(0, 2, 2, 8'h00, -1, "stuck0");
    run_seq(0, 2, 3, 8'($urandom), 6, "restart");

    // Reset for one edge during vector 5.
    mode[0] = 1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    chk("midrst.pre.vec_idx", int'(vec_idx[0]), 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_all(0, "midrst", 0, 1'b0, 1'b0, 0);
    chk_all(1, "midrst", 0, 1'b0, 1'b0, 0);
    last_err[0] = 0;
    last_err[1] = 0;
    for (int c = 0; c < 20; c++) begin
      chk_all(0, $sformatf("midrst.quiet%0d", c), 0, 1'b0, 1'b0, 0);
      @(posedge clk); #1;
    end
    run_seq(0, 2, 0, 8'h00, -1, "postrst");

    // DWELL=1 edge case.
    run_seq(1, 1, 1, 8'h00, -1, "d1.inv");
    run_seq(1, 1, 3, 8'($urandom), 3, "d1.rand");

    // Randomized runs with random idle gaps on both instances.
    for (int r = 0; r < 6; r++) begin
      int k;
      k = r % 2;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_seq(k, (k == 0) ? 2 : 1, int'($urandom_range(0, 3)), 8'($urandom),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1,
              $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
